// File: rtl/unidade_controle.sv
// Control unit for a small multicycle processor.
// The instruction walks through FETCH -> DECODE -> EXECUTE -> WRITEBACK.
// JMP and HLT finish in EXECUTE. HALT is left only by reset.
module unidade_controle #(
    parameter int unsigned PC_MAX = 99
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] inst_in,
    input  logic        ula_carry,
    output logic [15:0] op_counter,
    output logic [1:0]  reg1,
    output logic [1:0]  reg2,
    output logic [1:0]  reg3,
    output logic [2:0]  ula_cntrl,
    output logic        reg_we,
    output logic        imm_sel,
    output logic [15:0] imm_out,
    output logic        busy,
    output logic        halted,
    output logic        carry_flag
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StWriteback,
        StHalt
    } state_e;

    localparam logic [2:0]  OpAdd = 3'b000;
    localparam logic [2:0]  OpOr  = 3'b100;
    localparam logic [2:0]  OpLdi = 3'b101;
    localparam logic [2:0]  OpJmp = 3'b110;
    localparam logic [2:0]  OpHlt = 3'b111;
    localparam logic [15:0] PcMax = 16'(PC_MAX);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        carry_q, carry_d;

    logic [2:0]  opcode;
    logic [15:0] jmp_target;

    assign opcode     = ir_q[15:13];
    assign jmp_target = {8'h00, ir_q[7:0]};

    // Next-state logic for the FSM, program counter, instruction register and carry
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        carry_d = carry_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    pc_d    = '0;
                end
            end
            StFetch: begin
                state_d = StDecode;
            end
            StDecode: begin
                // Memory answers one cycle after the address was presented in FETCH
                ir_d    = inst_in;
                state_d = StExecute;
            end
            StExecute: begin
                if (opcode == OpJmp) begin
                    // Out-of-range targets restart the program rather than fetch garbage
                    pc_d    = (jmp_target <= PcMax) ? jmp_target : '0;
                    state_d = StFetch;
                end else if (opcode == OpHlt) begin
                    state_d = StHalt;
                end else begin
                    state_d = StWriteback;
                end
                if (opcode == OpAdd) begin
                    carry_d = ula_carry;
                end
            end
            StWriteback: begin
                pc_d    = (pc_q == PcMax) ? '0 : pc_q + 16'd1;
                state_d = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over everything
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            ir_q    <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
        end
    end

    // Output decode; operand fields are only driven in EXECUTE and WRITEBACK
    always_comb begin
        op_counter = pc_q;
        imm_out    = {8'h00, ir_q[7:0]};
        carry_flag = carry_q;
        busy       = (state_q != StIdle) && (state_q != StHalt);
        halted     = (state_q == StHalt);
        reg1       = '0;
        reg2       = '0;
        reg3       = '0;
        ula_cntrl  = '0;
        reg_we     = 1'b0;
        imm_sel    = 1'b0;
        if ((state_q == StExecute) || (state_q == StWriteback)) begin
            reg1      = ir_q[10:9];
            reg2      = ir_q[8:7];
            reg3      = ir_q[12:11];
            ula_cntrl = (opcode <= OpOr) ? opcode : 3'b000;
        end
        if (state_q == StWriteback) begin
            reg_we  = 1'b1;
            imm_sel = (opcode == OpLdi);
        end
    end

endmodule
